// File: rtl/adrv9001_enable_sequencer.sv
// rtl/adrv9001_enable_sequencer.sv - ADRV9001 reset sequencing and per-channel RX/TX enable arbitration
module adrv9001_enable_sequencer #(
    parameter int RST_PULSE_CYCLES  = 1000,
    parameter int RST_WAIT_CYCLES   = 10000,
    parameter int TURNAROUND_CYCLES = 100,
    parameter int CNT_WIDTH         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reset_req,
    input  logic [1:0] rx_en_req,
    input  logic [1:0] tx_en_req,
    output logic       ready,
    output logic [3:0] ch_state,
    output logic [1:0] conflict,
    output logic       adrv9001_rstn,
    output logic       adrv9001_rx1,
    output logic       adrv9001_rx2,
    output logic       adrv9001_tx1,
    output logic       adrv9001_tx2
);

    typedef enum logic [1:0] {RST_ASSERT = 2'd0, RST_WAIT = 2'd1, RUN = 2'd2} top_t;
    typedef enum logic [1:0] {CH_IDLE = 2'd0, CH_RX = 2'd1, CH_TX = 2'd2, CH_GUARD = 2'd3} ch_t;

    // Counters run 0..N-1 so the transition lands exactly on the N-th edge.
    localparam logic [CNT_WIDTH-1:0] PULSE_LAST = CNT_WIDTH'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] WAIT_LAST  = CNT_WIDTH'(RST_WAIT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] GUARD_LAST =
        CNT_WIDTH'((TURNAROUND_CYCLES > 0) ? TURNAROUND_CYCLES - 1 : 0);

    top_t                 top_q, top_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    ch_t                  ch_q [2];
    ch_t                  ch_d [2];
    logic [CNT_WIDTH-1:0] gcnt_q [2];
    logic [CNT_WIDTH-1:0] gcnt_d [2];
    logic [1:0]           conflict_q, conflict_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q      <= RST_ASSERT;
            cnt_q      <= '0;
            conflict_q <= '0;
            for (int i = 0; i < 2; i++) begin
                ch_q[i]   <= CH_IDLE;
                gcnt_q[i] <= '0;
            end
        end else begin
            top_q      <= top_d;
            cnt_q      <= cnt_d;
            conflict_q <= conflict_d;
            for (int i = 0; i < 2; i++) begin
                ch_q[i]   <= ch_d[i];
                gcnt_q[i] <= gcnt_d[i];
            end
        end
    end

    always_comb begin
        top_d = top_q;
        cnt_d = cnt_q;
        if (reset_req) begin
            top_d = RST_ASSERT;
            cnt_d = '0;
        end else begin
            case (top_q)
                RST_ASSERT: begin
                    if (cnt_q == PULSE_LAST) begin
                        top_d = RST_WAIT;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RST_WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        top_d = RUN;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN:     top_d = RUN;
                default: top_d = RST_ASSERT;
            endcase
        end
    end

    // Leaving RUN drops channels straight to IDLE; the guard only applies to normal disables.
    always_comb begin
        conflict_d = '0;
        for (int i = 0; i < 2; i++) begin
            ch_d[i]   = ch_q[i];
            gcnt_d[i] = gcnt_q[i];
            if (top_q != RUN || reset_req) begin
                ch_d[i]   = CH_IDLE;
                gcnt_d[i] = '0;
            end else begin
                case (ch_q[i])
                    CH_IDLE: begin
                        if (rx_en_req[i] && !tx_en_req[i])
                            ch_d[i] = CH_RX;
                        else if (tx_en_req[i] && !rx_en_req[i])
                            ch_d[i] = CH_TX;
                        else if (rx_en_req[i] && tx_en_req[i])
                            conflict_d[i] = 1'b1;
                    end
                    CH_RX: begin
                        conflict_d[i] = tx_en_req[i];
                        if (!rx_en_req[i]) begin
                            ch_d[i]   = (TURNAROUND_CYCLES == 0) ? CH_IDLE : CH_GUARD;
                            gcnt_d[i] = '0;
                        end
                    end
                    CH_TX: begin
                        conflict_d[i] = rx_en_req[i];
                        if (!tx_en_req[i]) begin
                            ch_d[i]   = (TURNAROUND_CYCLES == 0) ? CH_IDLE : CH_GUARD;
                            gcnt_d[i] = '0;
                        end
                    end
                    default: begin
                        if (gcnt_q[i] == GUARD_LAST) begin
                            ch_d[i]   = CH_IDLE;
                            gcnt_d[i] = '0;
                        end else begin
                            gcnt_d[i] = gcnt_q[i] + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign ready         = (top_q == RUN);
    assign adrv9001_rstn = (top_q != RST_ASSERT);
    assign ch_state      = {ch_q[1], ch_q[0]};
    assign conflict      = conflict_q;
    assign adrv9001_rx1  = (ch_q[0] == CH_RX);
    assign adrv9001_tx1  = (ch_q[0] == CH_TX);
    assign adrv9001_rx2  = (ch_q[1] == CH_RX);
    assign adrv9001_tx2  = (ch_q[1] == CH_TX);

endmodule

// File: doc/adrv9001_enable_sequencer.md
# adrv9001_enable_sequencer

Sequences the ADRV9001 control pins that are not handled by the DGPIO tristate path: device reset (`adrv9001_rstn`) and the four RX/TX enable pins. It runs a power-up reset sequence, then arbitrates per-channel RX/TX enable requests from the TDD/software logic. It enforces RX/TX mutual exclusion on each channel and a programmable turnaround guard after every disable. It sits between the PS/TDD control registers and the board pins, replacing direct GPIO drive of `rstn`, `rx1`, `rx2`, `tx1` and `tx2`.

## Interface
- `RST_PULSE_CYCLES`, 1000: clocks `adrv9001_rstn` is held low; must be ≥1.
- `RST_WAIT_CYCLES`, 10000: clocks from `rstn` release to `ready`; must be ≥1.
- `TURNAROUND_CYCLES`, 100: guard clocks with all enables low on a channel after it disables; 0 is legal.
- `CNT_WIDTH`, 16: width of all counters; must hold the largest of the three counts.

- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `reset_req`  in  1  level or pulse; each sampled-high cycle (re)starts the device reset sequence.
- `rx_en_req`  in  2  RX enable request, [0]=ch1, [1]=ch2, level-sensitive.
- `tx_en_req`  in  2  TX enable request, [0]=ch1, [1]=ch2, level-sensitive.
- `ready`  out  1  device out of reset and wait elapsed; requests are honoured only when high.
- `ch_state`  out  4  per channel 2 bits ([1:0]=ch1, [3:2]=ch2): 0 IDLE, 1 RX, 2 TX, 3 GUARD.
- `conflict`  out  2  per channel; high in any cycle where the channel's request is incompatible with its state.
- `adrv9001_rstn`  out  1  device reset, active low.
- `adrv9001_rx1`, `adrv9001_rx2`, `adrv9001_tx1`, `adrv9001_tx2`  out  1 each  enable pins.

## Operation
- Top FSM: RST_ASSERT → RST_WAIT → RUN.
  - RST_ASSERT: `rstn`=0; load counter with RST_PULSE_CYCLES; go to RST_WAIT when it expires.
  - RST_WAIT: `rstn`=1; count RST_WAIT_CYCLES, then go to RUN.
  - RUN: `ready`=1.
- `reset_req` high in any state → RST_ASSERT with the counter reloaded. This includes RST_ASSERT itself, so a held `reset_req` extends the pulse.
- Channel FSM (×2): IDLE, RX, TX, GUARD. It advances only in RUN and is forced to IDLE in other top states, bypassing GUARD.
  - IDLE: `rx_req & !tx_req` → RX; `tx_req & !rx_req` → TX; both high → stay IDLE and assert `conflict`.
  - RX: stay while `rx_req`=1. `tx_req`=1 while in RX asserts `conflict` and is ignored. When `rx_req`=0, go to GUARD (or IDLE if TURNAROUND_CYCLES=0).
  - TX: mirror of RX.
  - GUARD: count TURNAROUND_CYCLES, then IDLE. Requests in GUARD are ignored and do not assert `conflict`.
- Pins are decoded directly from registered state: `rxN` = (state==RX), `txN` = (state==TX). No combinational path from inputs to pins.
- Channels are independent. Both channels may be in TX, RX or mixed simultaneously.

## Timing
- Reset values, held while `rst`=1: `adrv9001_rstn`=0, all enables 0, `ready`=0, `ch_state`=0, `conflict`=0, top FSM in RST_ASSERT.
- `rstn` rises on the RST_PULSE_CYCLES-th rising edge after `rst` deasserts, counting the first edge with `rst` low as edge 1.
- `ready` rises RST_WAIT_CYCLES edges after `rstn` rises.
- `reset_req` sampled at edge E: at E, `rstn`→0, `ready`→0, all enables→0, states→IDLE. `rstn` rises RST_PULSE_CYCLES edges after the last edge at which `reset_req` was sampled high.
- Enable latency: a request sampled at edge E in IDLE (RUN) drives the pin high at E.
- Disable latency: a request sampled low at edge E drives the pin low at E.
- Minimum low time between any two enables on a channel: TURNAROUND_CYCLES+1 clocks (GUARD cycles plus one IDLE cycle).
- `conflict` is registered, one clock after the sampled condition.
- Counters saturate at terminal count; no wrap is reachable.

## Test plan
Parameters for all scenarios: RST_PULSE=4, RST_WAIT=8, TURNAROUND=3.
- Release `rst` → `rstn` high at edge 4, `ready` high at edge 12. All enables stay 0 with `rx_en_req`=2'b11 held throughout.
- Ch1 `rx_req` 1 for 5 clocks then 0, `tx_req` raised 1 clock after rx drops → `rx1` high 5 clocks, `ch_state[1:0]` = 3 for 3 clocks, then IDLE 1 clock, then `tx1` high. `rx1` and `tx1` are never both high.
- Ch2 `rx_req` and `tx_req` rise together in IDLE → state stays 0, `conflict[1]`=1 the following clock, pins low. Dropping `tx_req` → `rx2` high next edge.
- Ch1 in TX, Ch2 in RX; pulse `reset_req` 1 clock → all enables and `ready` low at the same edge. `rstn` low 4 clocks, `ready` returns 12 clocks after the pulse edge. No GUARD state is visited.
- TURNAROUND=0 rebuild: RX drop then TX request → exactly 1 IDLE clock between `rx1` fall and `tx1` rise.
- Assert `rst` mid-TX → `tx1` and `rstn` go 0 asynchronously, before the next clock edge.
